// File: rtl/isqrt_iter.sv
// Iterative restoring integer square root: floor(sqrt(x)) of a 32-bit radicand,
// resolving ITER_PER_CYCLE root bits per clock with a fixed latency of 16/ITER_PER_CYCLE.
module isqrt_iter #(
    parameter int unsigned ITER_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        x_vld,
    input  logic [31:0] x,
    output logic        y_vld,
    output logic [15:0] y,
    output logic        busy,
    output logic        ovf
);

    localparam int unsigned L       = 16 / ITER_PER_CYCLE;
    localparam int unsigned RemW    = 18;
    localparam int unsigned CntW    = 4;
    localparam int unsigned CntLoad = (L > 1) ? (L - 2) : 0;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [31:0]       x_q, x_d;
    logic [RemW-1:0]   rem_q, rem_d;
    logic [15:0]       root_q, root_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [15:0]       y_q, y_d;
    logic              ovf_q, ovf_d;

    logic              accept;
    logic [RemW-1:0]   rem_v;
    logic [15:0]       root_v;
    logic [31:0]       x_v;
    logic [RemW-1:0]   acc;
    logic [RemW:0]     trial;

    assign accept = x_vld && (state_q != StRun);

    // The accepting edge already resolves the first group of bits from a cleared
    // remainder/root, so only L-1 cycles are spent in RUN.
    always_comb begin
        rem_v  = accept ? '0 : rem_q;
        root_v = accept ? '0 : root_q;
        x_v    = accept ? x : x_q;
        acc    = '0;
        trial  = '0;
        for (int i = 0; i < int'(ITER_PER_CYCLE); i++) begin
            // Remainder before any shift fits in 16 bits, so the top bits drop safely.
            acc   = {rem_v[RemW-3:0], x_v[31:30]};
            trial = {1'b0, acc} - {1'b0, root_v, 2'b01};
            if (!trial[RemW]) begin
                rem_v  = trial[RemW-1:0];
                root_v = {root_v[14:0], 1'b1};
            end else begin
                rem_v  = acc;
                root_v = {root_v[14:0], 1'b0};
            end
            x_v = {x_v[29:0], 2'b00};
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        rem_d   = rem_q;
        root_d  = root_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        ovf_d   = ovf_q | (x_vld && (state_q == StRun));
        unique case (state_q)
            StIdle, StDone: begin
                if (accept) begin
                    x_d    = x_v;
                    rem_d  = rem_v;
                    root_d = root_v;
                    cnt_d  = CntW'(CntLoad);
                    if (L == 1) begin
                        state_d = StDone;
                        y_d     = root_v;
                    end else begin
                        state_d = StRun;
                    end
                end else begin
                    state_d = StIdle;
                end
            end
            StRun: begin
                x_d    = x_v;
                rem_d  = rem_v;
                root_d = root_v;
                if (cnt_q == '0) begin
                    state_d = StDone;
                    y_d     = root_v;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            x_q     <= '0;
            rem_q   <= '0;
            root_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            ovf_q   <= ovf_d;
        end
    end

    assign y_vld = (state_q == StDone);
    assign busy  = (state_q == StRun);
    assign y     = y_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_isqrt_iter.sv
// Bench for isqrt_iter: directed latency/overflow/reset scenarios at one bit per clock,
// randomized results at four bits per clock, all against an arithmetic square-root model.
module tb_isqrt_iter;

    logic        clk;
    logic        rst;
    logic        x1_vld, x4_vld;
    logic [31:0] x1, x4;
    logic        y1_vld, y4_vld;
    logic [15:0] y1, y4;
    logic        busy1, busy4;
    logic        ovf1, ovf4;

    int unsigned checks;
    int unsigned errors;
    logic [15:0] exp_y1;
    logic [15:0] exp_y4;

    isqrt_iter #(.ITER_PER_CYCLE(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x1_vld),
        .x     (x1),
        .y_vld (y1_vld),
        .y     (y1),
        .busy  (busy1),
        .ovf   (ovf1)
    );

    isqrt_iter #(.ITER_PER_CYCLE(4)) u_dut4 (
        .clk   (clk),
        .rst   (rst),
        .x_vld (x4_vld),
        .x     (x4),
        .y_vld (y4_vld),
        .y     (y4),
        .busy  (busy4),
        .ovf   (ovf4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned isqrt_ref(input logic [31:0] v);
        longint unsigned k;
        longint unsigned vv;
        vv = 64'(v);
        k  = longint'($rtoi($sqrt(real'(vv))));
        while (k * k > vv) k--;
        while ((k + 1) * (k + 1) <= vv) k++;
        return 32'(k);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        check_eq("rst_outs1", {y1_vld, busy1, ovf1}, 3'b000);
        check_eq("rst_y1", 32'(y1), 32'h0);
        check_eq("rst_outs4", {y4_vld, busy4, ovf4}, 3'b000);
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_y1 = '0;
        exp_y4 = '0;
    endtask

    // Presents v in the current cycle T and follows it to the y_vld cycle T+16 and one beyond.
    task automatic do1(input logic [31:0] v);
        logic [15:0] e;
        e      = 16'(isqrt_ref(v));
        x1     = v;
        x1_vld = 1'b1;
        tick();
        x1_vld = 1'b0;
        for (int k = 1; k < 16; k++) begin
            check_eq("i1_busy", {busy1, y1_vld}, 2'b10);
            check_eq("i1_hold", 32'(y1), 32'(exp_y1));
            tick();
        end
        check_eq("i1_vld", {busy1, y1_vld}, 2'b01);
        check_eq("i1_y", 32'(y1), 32'(e));
        exp_y1 = e;
        tick();
        check_eq("i1_after", {busy1, y1_vld}, 2'b00);
        check_eq("i1_keep", 32'(y1), 32'(e));
    endtask

    // Presents v in the current cycle (idle or DONE) and ends in its own DONE cycle.
    task automatic do4(input logic [31:0] v);
        logic [15:0]     e;
        longint unsigned yy;
        e      = 16'(isqrt_ref(v));
        x4     = v;
        x4_vld = 1'b1;
        tick();
        x4_vld = 1'b0;
        for (int k = 1; k < 4; k++) begin
            check_eq("i4_busy", {busy4, y4_vld}, 2'b10);
            check_eq("i4_hold", 32'(y4), 32'(exp_y4));
            tick();
        end
        check_eq("i4_vld", {busy4, y4_vld}, 2'b01);
        check_eq("i4_y", 32'(y4), 32'(e));
        yy = 64'(y4);
        check_eq("i4_bound", 32'((yy * yy <= 64'(v)) && ((yy + 1) * (yy + 1) > 64'(v))), 32'h1);
        exp_y4 = e;
    endtask

    initial begin
        logic [31:0] bset [$];
        logic [31:0] v;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        x1_vld = 1'b0;
        x4_vld = 1'b0;
        x1     = '0;
        x4     = '0;
        exp_y1 = '0;
        exp_y4 = '0;
        tick();
        tick();
        rst = 1'b0;
        check_eq("init_outs1", {y1_vld, busy1, ovf1}, 3'b000);
        check_eq("init_y1", 32'(y1), 32'h0);

        // Directed values at one bit per clock.
        do1(32'd0);
        do1(32'd16);
        do1(32'd15);
        do1(32'hFFFF_FFFF);
        for (int i = 0; i < 12; i++) do1($urandom);

        // A strobe during RUN is dropped and flags overflow.
        x1     = 32'd1000000;
        x1_vld = 1'b1;
        tick();
        x1_vld = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        check_eq("ovf_pre", 32'(ovf1), 32'h0);
        x1     = 32'd9;
        x1_vld = 1'b1;
        tick();
        x1_vld = 1'b0;
        check_eq("ovf_set", 32'(ovf1), 32'h1);
        for (int k = 6; k < 16; k++) begin
            check_eq("ovf_run", {busy1, y1_vld}, 2'b10);
            tick();
        end
        check_eq("ovf_vld", {busy1, y1_vld}, 2'b01);
        check_eq("ovf_y", 32'(y1), 32'd1000);
        for (int k = 0; k < 20; k++) begin
            tick();
            check_eq("ovf_nosecond", {busy1, y1_vld, ovf1}, 3'b001);
            check_eq("ovf_ykeep", 32'(y1), 32'd1000);
        end
        do_reset();

        // Back-to-back request accepted in the DONE cycle.
        x1     = 32'd81;
        x1_vld = 1'b1;
        tick();
        x1_vld = 1'b0;
        for (int k = 1; k < 16; k++) tick();
        check_eq("b2b_vld1", {busy1, y1_vld}, 2'b01);
        check_eq("b2b_y1", 32'(y1), 32'd9);
        x1     = 32'h4000_0000;
        x1_vld = 1'b1;
        tick();
        x1_vld = 1'b0;
        for (int k = 17; k < 32; k++) begin
            check_eq("b2b_run", {busy1, y1_vld}, 2'b10);
            check_eq("b2b_hold", 32'(y1), 32'd9);
            tick();
        end
        check_eq("b2b_vld2", {busy1, y1_vld}, 2'b01);
        check_eq("b2b_y2", 32'(y1), 32'h8000);
        check_eq("b2b_ovf", 32'(ovf1), 32'h0);
        tick();
        exp_y1 = 16'h8000;

        // Reset mid-RUN aborts; a strobe under reset is ignored.
        x1     = 32'd144;
        x1_vld = 1'b1;
        tick();
        x1_vld = 1'b0;
        for (int k = 1; k < 7; k++) tick();
        rst    = 1'b1;
        x1     = 32'd9;
        x1_vld = 1'b1;
        #1;
        check_eq("abort_outs", {y1_vld, busy1, ovf1}, 3'b000);
        check_eq("abort_y", 32'(y1), 32'h0);
        tick();
        rst    = 1'b0;
        x1_vld = 1'b0;
        exp_y1 = '0;
        check_eq("abort_idle", {y1_vld, busy1}, 2'b00);
        do1(32'd4);

        // Four bits per clock: boundary set, then random with mixed idle gaps.
        bset = '{32'd0, 32'hFFFF_FFFF, 32'd1, 32'd4, 32'd3, 32'd9, 32'd8, 32'd10000, 32'd9999,
                 32'h0100_0000, 32'h00FF_FFFF, 32'hFFFE_0001, 32'hFFFE_0000};
        foreach (bset[i]) begin
            do4(bset[i]);
            tick();
        end
        for (int i = 0; i < 10000; i++) begin
            v = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 4096)) : $urandom;
            do4(v);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
        check_eq("i4_ovf", 32'(ovf4), 32'h0);
        check_eq("i4_idle", {busy4, y4_vld}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
